// File: rtl/control_output_schedule.sv
// ============================================================================
// Module   : control_output_schedule
// Brief    : Two-queue (TS/BE) descriptor scheduler feeding control_tx with
//            strict TS>BE priority and a post-issue guard window.
//            Optional macro CONTROL_OS_STAT_EN adds 16-bit per-queue drop counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_output_schedule_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 14
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_usedw,
    output logic                     o_drop
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam int              c_UW   = c_AW + 1;
    localparam logic [c_UW-1:0] c_FULL = c_UW'(DEPTH);
    localparam logic [c_UW-1:0] c_ONE  = c_UW'(1);
    localparam logic [c_AW-1:0] c_PINC = c_AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_UW-1:0]  r_usedw;
    logic             r_drop;
    logic             w_push_ok;
    logic             w_pop_ok;

    // Fullness is judged on the registered count, so a same-cycle pop never rescues a push.
    assign w_push_ok = i_push && (r_usedw != c_FULL);
    assign w_pop_ok  = i_pop && (r_usedw != '0);

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PINC;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_PINC;
            end
            r_drop <= i_push && !w_push_ok;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_usedw <= r_usedw + c_ONE;
                2'b01:   r_usedw <= r_usedw - c_ONE;
                default: r_usedw <= r_usedw;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_usedw = r_usedw;
    assign o_drop  = r_drop;

endmodule

module control_output_schedule #(
    parameter int TS_DEPTH     = 16,
    parameter int BE_DEPTH     = 32,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [13:0]                 iv_ts_descriptor,
    input  logic                        i_ts_descriptor_wr,
    input  logic [13:0]                 iv_be_descriptor,
    input  logic                        i_be_descriptor_wr,
    input  logic                        i_pkt_descriptor_ready,
    output logic [13:0]                 ov_pkt_descriptor,
    output logic                        o_pkt_descriptor_wr,
    output logic [$clog2(TS_DEPTH):0]   ov_ts_usedw,
    output logic [$clog2(BE_DEPTH):0]   ov_be_usedw,
    output logic                        o_ts_drop_pulse,
    output logic                        o_be_drop_pulse
`ifdef CONTROL_OS_STAT_EN
    ,
    output logic [15:0]                 ov_ts_drop_cnt,
    output logic [15:0]                 ov_be_drop_cnt
`endif
);

    localparam int             c_GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [c_GW-1:0] c_GUARD_LOAD = c_GW'(GUARD_CYCLES - 1);
    localparam logic [c_GW-1:0] c_GUARD_DEC  = c_GW'(1);
    localparam logic [0:0]     c_ST_IDLE    = 1'b0;
    localparam logic [0:0]     c_ST_GUARD   = 1'b1;

    logic [13:0]               w_ts_head;
    logic [13:0]               w_be_head;
    logic [$clog2(TS_DEPTH):0] w_ts_usedw;
    logic [$clog2(BE_DEPTH):0] w_be_usedw;
    logic                      w_ts_drop;
    logic                      w_be_drop;

    logic [0:0]                r_state;
    logic [0:0]                w_state_next;
    logic [c_GW-1:0]           r_guard_cnt;
    logic                      w_issue;
    logic                      w_pop_ts;
    logic                      w_pop_be;
    logic [13:0]               w_issue_desc;
    logic [13:0]               r_pkt_desc;
    logic                      r_pkt_wr;

    control_output_schedule_fifo #(
        .DEPTH (TS_DEPTH),
        .WIDTH (14)
    ) u_ts_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_ts_descriptor_wr),
        .i_din   (iv_ts_descriptor),
        .i_pop   (w_pop_ts),
        .o_head  (w_ts_head),
        .o_usedw (w_ts_usedw),
        .o_drop  (w_ts_drop)
    );

    control_output_schedule_fifo #(
        .DEPTH (BE_DEPTH),
        .WIDTH (14)
    ) u_be_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_be_descriptor_wr),
        .i_din   (iv_be_descriptor),
        .i_pop   (w_pop_be),
        .o_head  (w_be_head),
        .o_usedw (w_be_usedw),
        .o_drop  (w_be_drop)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= c_ST_IDLE;
            r_guard_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_guard_cnt <= c_GUARD_LOAD;
            end else if ((r_state == c_ST_GUARD) && (r_guard_cnt != '0)) begin
                r_guard_cnt <= r_guard_cnt - c_GUARD_DEC;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_issue) w_state_next = c_ST_GUARD;
            c_ST_GUARD: if (r_guard_cnt == '0) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Priority looks only at registered occupancy; a same-cycle TS push cannot preempt a BE pick.
    always_comb begin
        w_issue      = 1'b0;
        w_pop_ts     = 1'b0;
        w_pop_be     = 1'b0;
        w_issue_desc = w_be_head;
        if ((r_state == c_ST_IDLE) && i_pkt_descriptor_ready &&
            ((w_ts_usedw != '0) || (w_be_usedw != '0))) begin
            w_issue = 1'b1;
            if (w_ts_usedw != '0) begin
                w_pop_ts     = 1'b1;
                w_issue_desc = w_ts_head;
            end else begin
                w_pop_be     = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pkt_desc <= '0;
            r_pkt_wr   <= 1'b0;
        end else begin
            r_pkt_wr <= w_issue;
            if (w_issue) begin
                r_pkt_desc <= w_issue_desc;
            end
        end
    end

    assign ov_pkt_descriptor   = r_pkt_desc;
    assign o_pkt_descriptor_wr = r_pkt_wr;
    assign ov_ts_usedw         = w_ts_usedw;
    assign ov_be_usedw         = w_be_usedw;
    assign o_ts_drop_pulse     = w_ts_drop;
    assign o_be_drop_pulse     = w_be_drop;

`ifdef CONTROL_OS_STAT_EN
    logic [15:0] r_ts_drop_cnt;
    logic [15:0] r_be_drop_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ts_drop_cnt <= '0;
            r_be_drop_cnt <= '0;
        end else begin
            if (w_ts_drop) r_ts_drop_cnt <= r_ts_drop_cnt + 16'd1;
            if (w_be_drop) r_be_drop_cnt <= r_be_drop_cnt + 16'd1;
        end
    end

    assign ov_ts_drop_cnt = r_ts_drop_cnt;
    assign ov_be_drop_cnt = r_be_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_control_output_schedule.sv
// ============================================================================
// Module   : tb_control_output_schedule
// Brief    : Directed scoreboard bench for control_output_schedule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_output_schedule;

    logic        clk;
    logic        rst;
    logic [13:0] ts_desc;
    logic        ts_wr;
    logic [13:0] be_desc;
    logic        be_wr;
    logic        ready;
    logic [13:0] pkt_desc;
    logic        pkt_wr;
    logic [4:0]  ts_usedw;
    logic [5:0]  be_usedw;
    logic        ts_drop;
    logic        be_drop;
`ifdef CONTROL_OS_STAT_EN
    logic [15:0] ts_drop_cnt;
    logic [15:0] be_drop_cnt;
`endif

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          prev_cyc = -100;
    logic [13:0] exp_q[$];

    control_output_schedule #(
        .TS_DEPTH     (16),
        .BE_DEPTH     (32),
        .GUARD_CYCLES (2)
    ) dut (
        .i_clk                  (clk),
        .i_rst                  (rst),
        .iv_ts_descriptor       (ts_desc),
        .i_ts_descriptor_wr     (ts_wr),
        .iv_be_descriptor       (be_desc),
        .i_be_descriptor_wr     (be_wr),
        .i_pkt_descriptor_ready (ready),
        .ov_pkt_descriptor      (pkt_desc),
        .o_pkt_descriptor_wr    (pkt_wr),
        .ov_ts_usedw            (ts_usedw),
        .ov_be_usedw            (be_usedw),
        .o_ts_drop_pulse        (ts_drop),
        .o_be_drop_pulse        (be_drop)
`ifdef CONTROL_OS_STAT_EN
        ,
        .ov_ts_drop_cnt         (ts_drop_cnt),
        .ov_be_drop_cnt         (be_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // n-1 quiet cycles, then the issue of d
    task automatic issue_after(input int n, input logic [13:0] d);
        for (int i = 1; i <= n; i++) begin
            step();
            if (i < n) begin
                chk("gap_wr", {31'd0, pkt_wr}, 32'd0);
            end else begin
                chk("issue_wr", {31'd0, pkt_wr}, 32'd1);
                chk("issue_desc", {18'd0, pkt_desc}, {18'd0, d});
            end
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk("drain_left", exp_q.size(), 32'd0);
        for (int i = 0; i < 4; i++) step();
    endtask

    initial begin
        logic [13:0] want;
        rst = 1'b1; ts_desc = '0; ts_wr = 1'b0; be_desc = '0; be_wr = 1'b0; ready = 1'b0;

        fork
            forever begin
                @(posedge clk);
                cyc++;
            end
            forever begin
                @(negedge clk);
                if (pkt_wr === 1'b1) begin
                    total++;
                    assert (exp_q.size() != 0) else begin
                        bad++;
                        $error("FAIL unexpected_issue got=%0h want=none", pkt_desc);
                    end
                    if (exp_q.size() != 0) begin
                        want = exp_q.pop_front();
                        chk("sb_order", {18'd0, pkt_desc}, {18'd0, want});
                    end
                    if (prev_cyc >= 0) begin
                        total++;
                        assert (cyc - prev_cyc >= 3) else begin
                            bad++;
                            $error("FAIL spacing got=%0d want>=3", cyc - prev_cyc);
                        end
                    end
                    prev_cyc = cyc;
                end
            end
        join_none

        step(); step();
        chk("rst_wr", {31'd0, pkt_wr}, 32'd0);
        chk("rst_desc", {18'd0, pkt_desc}, 32'd0);
        chk("rst_ts_usedw", {27'd0, ts_usedw}, 32'd0);
        chk("rst_be_usedw", {26'd0, be_usedw}, 32'd0);
        chk("rst_drops", {30'd0, ts_drop, be_drop}, 32'd0);
        rst = 1'b0;
        step();

        // single TS descriptor latency
        ts_desc = 14'h0012; ts_wr = 1'b1; ready = 1'b1; exp_q.push_back(14'h0012);
        step();
        ts_wr = 1'b0;
        chk("t1_usedw1", {27'd0, ts_usedw}, 32'd1);
        chk("t1_nowr", {31'd0, pkt_wr}, 32'd0);
        issue_after(1, 14'h0012);
        chk("t1_usedw0", {27'd0, ts_usedw}, 32'd0);
        step(); step(); step();

        // simultaneous TS/BE: TS first
        be_desc = 14'h0100; be_wr = 1'b1; ts_desc = 14'h0005; ts_wr = 1'b1;
        exp_q.push_back(14'h0005); exp_q.push_back(14'h0100);
        step();
        be_wr = 1'b0; ts_wr = 1'b0;
        chk("t2_ts_usedw", {27'd0, ts_usedw}, 32'd1);
        chk("t2_be_usedw", {26'd0, be_usedw}, 32'd1);
        issue_after(1, 14'h0005);
        issue_after(3, 14'h0100);
        step(); step(); step();

        // TS overflow
        ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            ts_wr = 1'b1;
            ts_desc = (i == 16) ? 14'h3FFF : 14'(14'h0020 + i);
            if (i < 16) exp_q.push_back(ts_desc);
            step();
        end
        ts_wr = 1'b0;
        chk("t3_usedw_full", {27'd0, ts_usedw}, 32'd16);
        chk("t3_drop_hi", {31'd0, ts_drop}, 32'd1);
        step();
        chk("t3_drop_lo", {31'd0, ts_drop}, 32'd0);
        chk("t3_usedw_hold", {27'd0, ts_usedw}, 32'd16);
`ifdef CONTROL_OS_STAT_EN
        chk("t3_drop_cnt", {16'd0, ts_drop_cnt}, 32'd1);
`endif
        ready = 1'b1;
        drain(100);
        chk("t3_usedw_empty", {27'd0, ts_usedw}, 32'd0);

        // ready held low, then FIFO-order BE issues
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            be_wr = 1'b1; be_desc = 14'(14'h0101 + i); exp_q.push_back(be_desc);
            step();
        end
        be_wr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_wr", {31'd0, pkt_wr}, 32'd0);
            chk("t4_hold_usedw", {26'd0, be_usedw}, 32'd3);
        end
        ready = 1'b1;
        issue_after(1, 14'h0101);
        issue_after(3, 14'h0102);
        issue_after(3, 14'h0103);
        step(); step(); step();
        chk("t4_usedw_empty", {26'd0, be_usedw}, 32'd0);

        // reset during GUARD
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ts_wr = 1'b1; ts_desc = 14'(14'h0200 + i);
            if (i == 0) exp_q.push_back(ts_desc);
            step();
        end
        ts_wr = 1'b0; ready = 1'b1;
        issue_after(1, 14'h0200);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_ts_usedw", {27'd0, ts_usedw}, 32'd0);
        chk("t5_be_usedw", {26'd0, be_usedw}, 32'd0);
        chk("t5_wr", {31'd0, pkt_wr}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t5_quiet", {31'd0, pkt_wr}, 32'd0);
        end

        // full BE with simultaneous push and issue-pop
        ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            be_wr = 1'b1; be_desc = 14'(14'h0300 + i); exp_q.push_back(be_desc);
            step();
        end
        chk("t6_usedw_full", {26'd0, be_usedw}, 32'd32);
        be_desc = 14'h3ABC; ready = 1'b1;
        step();
        be_wr = 1'b0;
        chk("t6_usedw", {26'd0, be_usedw}, 32'd31);
        chk("t6_drop_hi", {31'd0, be_drop}, 32'd1);
        chk("t6_wr", {31'd0, pkt_wr}, 32'd1);
        step();
        chk("t6_drop_lo", {31'd0, be_drop}, 32'd0);
`ifdef CONTROL_OS_STAT_EN
        chk("t6_drop_cnt", {16'd0, be_drop_cnt}, 32'd1);
`endif
        drain(200);

        // TS push in the deciding cycle does not preempt BE
        ready = 1'b0;
        be_wr = 1'b1; be_desc = 14'h00AA; exp_q.push_back(14'h00AA);
        step();
        be_wr = 1'b0; ready = 1'b1; ts_wr = 1'b1; ts_desc = 14'h0055; exp_q.push_back(14'h0055);
        issue_after(1, 14'h00AA);
        ts_wr = 1'b0;
        chk("t7_ts_usedw", {27'd0, ts_usedw}, 32'd1);
        issue_after(3, 14'h0055);
        drain(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
